// File: rtl/jogo_pkg.sv
// ---------------------------------------------------------------------------
// jogo_pkg
// Shared definitions for the switch-matching game: button count, debounce
// lengths for hardware and simulation, and the input-conditioner FSM states.
// No ports; imported by detector_jogada and its testbench.
// ---------------------------------------------------------------------------
package jogo_pkg;

  localparam int N_BOTOES         = 4;
  localparam int DEBOUNCE_DEFAULT = 500000;
  localparam int DEBOUNCE_SIM     = 4;

  // Encodings are visible on the 7-segment debug display, so keep them fixed.
  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    FILTRA_PRESS = 2'd1,
    PRESSIONADO  = 2'd2,
    FILTRA_SOLTA = 2'd3
  } estado_t;

endpackage

// File: rtl/sincronizador_2ff.sv
// ---------------------------------------------------------------------------
// sincronizador_2ff
// Plain two-flop synchroniser for asynchronous inputs (buttons, iniciar).
// Ports:
//   clock  in  1  destination clock
//   reset  in  1  synchronous, active-high; clears both stages
//   d      in  W  asynchronous input
//   q      out W  synchronised output (two clock edges of latency)
// ---------------------------------------------------------------------------
module sincronizador_2ff #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// ---------------------------------------------------------------------------
// detector_jogada
// Input conditioner for the game: synchronises the raw buttons, debounces
// both press and release, and turns each confirmed press into a single-cycle
// event (valid one-hot play or invalid multi-button play).
// Ports:
//   clock            in  1         system clock
//   reset            in  1         synchronous, active-high
//   chaves           in  N_BOTOES  raw asynchronous buttons, active-high
//   habilita         in  1         presses are accepted only while high
//   jogada           out N_BOTOES  one-hot code of the last accepted press
//   jogada_feita     out 1         one-cycle pulse for an accepted press
//   jogada_invalida  out 1         one-cycle pulse for a multi-button press
//   db_estado        out 4         FSM state code for debug display
// ---------------------------------------------------------------------------
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = jogo_pkg::DEBOUNCE_DEFAULT,
  parameter int N_BOTOES        = jogo_pkg::N_BOTOES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] chaves,
  input  logic                habilita,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_feita,
  output logic                jogada_invalida,
  output logic [3:0]          db_estado
);

  import jogo_pkg::*;

  // A single-cycle debounce still needs a 1-bit counter to exist.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BOTOES-1:0] s;
  logic                any_pressed;

  estado_t             estado, estado_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [N_BOTOES-1:0] amostra, amostra_next;
  logic [N_BOTOES-1:0] jogada_next;
  logic                feita_next, invalida_next;
  logic                um_quente;

  sincronizador_2ff #(.W(N_BOTOES)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (chaves),
    .q     (s)
  );

  assign any_pressed = |s;

  // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit.
  assign um_quente = (amostra != '0) &&
                     ((amostra & (amostra - N_BOTOES'(1))) == '0);

  // All state, counter, candidate pattern and outputs are registered here so
  // no path exists from chaves/habilita to any output.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado          <= OCIOSO;
      cnt             <= '0;
      amostra         <= '0;
      jogada          <= '0;
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
    end else begin
      estado          <= estado_next;
      cnt             <= cnt_next;
      amostra         <= amostra_next;
      jogada          <= jogada_next;
      jogada_feita    <= feita_next;
      jogada_invalida <= invalida_next;
    end
  end

  // Next-state logic. Pulses are only produced on the single FILTRA_PRESS ->
  // PRESSIONADO transition, and PRESSIONADO must be left through a full
  // release debounce, which keeps pulses isolated and mutually exclusive.
  always_comb begin
    estado_next   = estado;
    cnt_next      = cnt;
    amostra_next  = amostra;
    jogada_next   = jogada;
    feita_next    = 1'b0;
    invalida_next = 1'b0;

    case (estado)
      OCIOSO: begin
        if (any_pressed && habilita) begin
          estado_next  = FILTRA_PRESS;
          amostra_next = s;
          cnt_next     = '0;
        end else if (any_pressed) begin
          // Held while disabled: wait for the release without reporting it.
          estado_next = PRESSIONADO;
        end
      end

      FILTRA_PRESS: begin
        if (!habilita) begin
          estado_next = OCIOSO;
        end else if (s != amostra) begin
          estado_next = OCIOSO;
        end else if (cnt == CNT_MAX) begin
          estado_next = PRESSIONADO;
          if (um_quente) begin
            jogada_next = amostra;
            feita_next  = 1'b1;
          end else begin
            invalida_next = 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      PRESSIONADO: begin
        if (!any_pressed) begin
          estado_next = FILTRA_SOLTA;
          cnt_next    = '0;
        end
      end

      FILTRA_SOLTA: begin
        if (any_pressed) begin
          estado_next = PRESSIONADO;
        end else if (cnt == CNT_MAX) begin
          estado_next = OCIOSO;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: estado_next = OCIOSO;
    endcase
  end

  assign db_estado = {2'b00, estado};

endmodule

// File: tb/tb_detector_jogada.sv
// ---------------------------------------------------------------------------
// tb_detector_jogada
// Self-checking bench for detector_jogada with a short debounce. Stimulus
// pushes expected pulses (kind, code, cycle) into a scoreboard; a monitor
// pops and compares whenever a pulse appears.
// ---------------------------------------------------------------------------
module tb_detector_jogada;

  import jogo_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] chaves;
  logic       habilita;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic [3:0] db_estado;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    bit         invalida;
    logic [3:0] jogada;
    int         ciclo;
  } esperado_t;

  esperado_t sb[$];

  detector_jogada #(
    .DEBOUNCE_CYCLES (DEBOUNCE_SIM),
    .N_BOTOES        (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .chaves          (chaves),
    .habilita        (habilita),
    .jogada          (jogada),
    .jogada_feita    (jogada_feita),
    .jogada_invalida (jogada_invalida),
    .db_estado       (db_estado)
  );

  // 100 MHz-style simulation clock; period is irrelevant to the design.
  always #5 clock = ~clock;

  // Rising-edge counter used to time pulses relative to stimulus.
  always @(posedge clock) cyc <= cyc + 1;

  // Safety net: the stimulus is finite, but never let a broken DUT hang us.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [3:0] pattern, input logic hab);
    chaves   = pattern;
    habilita = hab;
  endtask

  task automatic expectPulse(input bit inval, input logic [3:0] jog, input int at_cyc);
    esperado_t e;
    e.invalida = inval;
    e.jogada   = jog;
    e.ciclo    = at_cyc;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string nome, input logic [31:0] atual,
                             input logic [31:0] esperado);
    tests_run++;
    if (atual !== esperado) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest pending expectation, arrive on
  // the expected cycle, and respect exclusivity / no back-to-back pulses.
  logic pulso_ant = 1'b0;
  always @(negedge clock) begin
    esperado_t e;
    if (jogada_feita || jogada_invalida) begin
      tests_run++;
      if (jogada_feita && jogada_invalida) begin
        tests_failed++;
        $display("[TB] FAIL pulse_exclusive: both pulses high at cycle %0d", cyc);
      end else if (pulso_ant) begin
        tests_failed++;
        $display("[TB] FAIL pulse_width: pulse high for 2 cycles at cycle %0d", cyc);
      end else if (sb.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL pulse_unexpected: feita=%0b invalida=%0b jogada=%b at cycle %0d, none expected",
                 jogada_feita, jogada_invalida, jogada, cyc);
      end else begin
        e = sb.pop_front();
        if (jogada_invalida !== e.invalida || jogada !== e.jogada || cyc != e.ciclo) begin
          tests_failed++;
          $display("[TB] FAIL pulse: got invalida=%0b jogada=%b cycle=%0d, expected invalida=%0b jogada=%b cycle=%0d",
                   jogada_invalida, jogada, cyc, e.invalida, e.jogada, e.ciclo);
        end
      end
    end
    pulso_ant = jogada_feita || jogada_invalida;
  end

  initial begin
    int c;
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b1);
    waitCycles(3);

    // Reset state
    checkOutput("reset_db_estado", 32'(db_estado), 32'd0);
    checkOutput("reset_jogada", 32'(jogada), 32'd0);
    checkOutput("reset_feita", 32'(jogada_feita), 32'd0);
    checkOutput("reset_invalida", 32'(jogada_invalida), 32'd0);
    reset = 1'b0;
    waitCycles(2);

    // 1: clean press of 0100, state trace 0 -> 1 -> 2 -> 3 -> 0
    c = cyc;
    applyStimulus(4'b0100, 1'b1);
    expectPulse(1'b0, 4'b0100, c + 7);
    waitCycles(2);
    checkOutput("s1_db_before", 32'(db_estado), 32'd0);
    waitCycles(1);
    checkOutput("s1_db_filtra_press", 32'(db_estado), 32'd1);
    waitCycles(3);
    checkOutput("s1_db_filtra_press_end", 32'(db_estado), 32'd1);
    waitCycles(1);
    checkOutput("s1_db_pressionado", 32'(db_estado), 32'd2);
    waitCycles(13);
    c = cyc;
    applyStimulus(4'b0000, 1'b1);
    waitCycles(3);
    checkOutput("s1_db_filtra_solta", 32'(db_estado), 32'd3);
    waitCycles(3);
    checkOutput("s1_db_filtra_solta_end", 32'(db_estado), 32'd3);
    waitCycles(1);
    checkOutput("s1_db_ocioso", 32'(db_estado), 32'd0);
    checkOutput("s1_jogada_held", 32'(jogada), 32'h4);
    waitCycles(5);

    // 3: multi-button press 0011 -> invalid pulse, jogada keeps 0100
    c = cyc;
    applyStimulus(4'b0011, 1'b1);
    expectPulse(1'b1, 4'b0100, c + 7);
    waitCycles(20);
    checkOutput("s3_jogada_kept", 32'(jogada), 32'h4);
    applyStimulus(4'b0000, 1'b1);
    waitCycles(12);

    // 2: bounce 0010/0000 for 6 cycles, then a steady 0010
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1);
      waitCycles(1);
    end
    c = cyc;
    applyStimulus(4'b0010, 1'b1);
    expectPulse(1'b0, 4'b0010, c + 7);
    waitCycles(20);
    checkOutput("s2_jogada", 32'(jogada), 32'h2);
    applyStimulus(4'b0000, 1'b1);
    waitCycles(12);

    // 4: 1000 held while disabled, enable, release, press again
    applyStimulus(4'b1000, 1'b0);
    waitCycles(10);
    checkOutput("s4_db_held_disabled", 32'(db_estado), 32'd2);
    applyStimulus(4'b1000, 1'b1);
    waitCycles(10);
    checkOutput("s4_db_held_enabled", 32'(db_estado), 32'd2);
    checkOutput("s4_jogada_unchanged", 32'(jogada), 32'h2);
    applyStimulus(4'b0000, 1'b1);
    waitCycles(12);
    checkOutput("s4_db_released", 32'(db_estado), 32'd0);
    c = cyc;
    applyStimulus(4'b1000, 1'b1);
    expectPulse(1'b0, 4'b1000, c + 7);
    waitCycles(20);
    checkOutput("s4_jogada", 32'(jogada), 32'h8);
    applyStimulus(4'b0000, 1'b1);
    waitCycles(12);

    // 5: habilita dropped during FILTRA_PRESS -> back to OCIOSO, no pulse
    applyStimulus(4'b0001, 1'b1);
    waitCycles(3);
    checkOutput("s5_db_filtra_press", 32'(db_estado), 32'd1);
    applyStimulus(4'b0001, 1'b0);
    waitCycles(1);
    checkOutput("s5_db_aborted", 32'(db_estado), 32'd0);
    waitCycles(8);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(12);
    checkOutput("s5_jogada_unchanged", 32'(jogada), 32'h8);
    applyStimulus(4'b0000, 1'b1);
    waitCycles(2);

    // 6: reset while PRESSIONADO, then button held through reset
    c = cyc;
    applyStimulus(4'b0100, 1'b1);
    expectPulse(1'b0, 4'b0100, c + 7);
    waitCycles(10);
    checkOutput("s6_db_pressionado", 32'(db_estado), 32'd2);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("s6_reset_db", 32'(db_estado), 32'd0);
    checkOutput("s6_reset_jogada", 32'(jogada), 32'd0);
    checkOutput("s6_reset_feita", 32'(jogada_feita), 32'd0);
    checkOutput("s6_reset_invalida", 32'(jogada_invalida), 32'd0);
    waitCycles(1);
    c = cyc;
    reset = 1'b0;
    expectPulse(1'b0, 4'b0100, c + 7);
    waitCycles(20);
    checkOutput("s6_jogada_after_reset", 32'(jogada), 32'h4);
    applyStimulus(4'b0000, 1'b1);
    waitCycles(15);

    // Every expected pulse must have been observed.
    checkOutput("scoreboard_pending", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
